// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op codes, FSM states
// and small op-classification helpers that the decoder reuses.
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'b000,
      MDU_MULTU = 3'b001,
      MDU_DIV   = 3'b010,
      MDU_DIVU  = 3'b011,
      MDU_MTHI  = 3'b100,
      MDU_MTLO  = 3'b101
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_FIN  = 2'b11
   } mdu_state_e;

   // Codes 000..011 are the four iterative arithmetic ops.
   function automatic logic mdu_is_arith(input logic [2:0] op);
      return ~op[2];
   endfunction

   function automatic logic mdu_is_signed(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic mdu_is_div(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-divide iteration: shifted partial remainder vs divisor.
module mdu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_part,
   input  logic [WIDTH-1:0] i_dvsr,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   // When the subtract succeeds the true difference is below the divisor,
   // so the low WIDTH bits of the difference are exact.
   assign o_qbit = (i_part >= {1'b0, i_dvsr});
   assign o_rem  = o_qbit ? (i_part[WIDTH-1:0] - i_dvsr) : i_part[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO write here directly
//   CALC  | WIDTH iterations of shift-add multiply / restoring divide
//   FIX   | sign correction of magnitude result, commit on exit
//   FIN   | HI/LO hold new result, done pulses, back to IDLE
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   mdu_state_e         r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opb;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic               r_busy;
   logic               r_done;
   logic               r_div0;

   logic               w_signed;
   logic               w_s1;
   logic               w_s2;
   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic [WIDTH:0]     w_msum;
   logic [WIDTH-1:0]   w_drem;
   logic               w_qbit;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_signed = mdu_is_signed(op);
   assign w_s1     = w_signed & in1[WIDTH-1];
   assign w_s2     = w_signed & in2[WIDTH-1];
   assign w_mag1   = w_s1 ? -in1 : in1;
   assign w_mag2   = w_s2 ? -in2 : in2;

   // r_acc holds {partial, multiplier/dividend}; both algorithms shift one bit per cycle.
   assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

   mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
      .i_part ({r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]}),
      .i_dvsr (r_opb),
      .o_rem  (w_drem),
      .o_qbit (w_qbit)
   );

   assign w_acc_next = r_is_div ? {w_drem, r_acc[WIDTH-2:0], w_qbit}
                                : {w_msum, r_acc[WIDTH-1:1]};

   // Most-negative magnitudes negate back to themselves, which gives the
   // MIN / -1 wrap-around without any special case.
   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   // Control FSM, datapath and architectural registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opb    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_div0   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && !cancel) begin
                  if (op == MDU_MTHI) begin
                     r_hi <= in1;
                  end else if (op == MDU_MTLO) begin
                     r_lo <= in1;
                  end else if (mdu_is_arith(op)) begin
                     r_acc    <= {{WIDTH{1'b0}}, w_mag1};
                     r_opb    <= w_mag2;
                     r_is_div <= mdu_is_div(op);
                     r_neg_q  <= w_s1 ^ w_s2;
                     r_neg_r  <= w_s1 & mdu_is_div(op);
                     r_dz     <= (in2 == '0);
                     r_cnt    <= CNT_LOAD;
                     r_busy   <= 1'b1;
                     r_state  <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (cancel) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt - CNT_ONE;
                  if (r_cnt == CNT_ONE) begin
                     r_state <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               if (cancel) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  if (r_is_div) begin
                     r_hi   <= w_rem;
                     r_lo   <= r_dz ? '1 : w_quo;
                     r_div0 <= r_dz;
                  end else begin
                     r_hi <= w_prod[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod[WIDTH-1:0];
                  end
                  r_done  <= 1'b1;
                  r_state <= ST_FIN;
               end
            end
            ST_FIN: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign div0 = r_div0;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: a 32-bit and an 8-bit instance driven by directed and
// random ops, checked against an arithmetic reference model.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        st32, cn32, busy32, done32, dz32;
   logic [2:0]  op32;
   logic [31:0] a32, b32, hi32, lo32;
   logic        st8, cn8, busy8, done8, dz8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, hi8, lo8;

   int total = 0;
   int bad   = 0;

   logic [31:0] e_hi [2];
   logic [31:0] e_lo [2];
   logic        e_dz [2];

   mult_div_unit #(.WIDTH(32)) u32 (
      .clk(clk), .reset(rst_n), .start(st32), .op(op32), .in1(a32), .in2(b32),
      .cancel(cn32), .busy(busy32), .done(done32), .div0(dz32), .hi(hi32), .lo(lo32)
   );

   mult_div_unit #(.WIDTH(8)) u8 (
      .clk(clk), .reset(rst_n), .start(st8), .op(op8), .in1(a8), .in2(b8),
      .cancel(cn8), .busy(busy8), .done(done8), .div0(dz8), .hi(hi8), .lo(lo8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic g_busy(input int s); return s != 0 ? busy8 : busy32; endfunction
   function automatic logic g_done(input int s); return s != 0 ? done8 : done32; endfunction
   function automatic logic g_dz(input int s);   return s != 0 ? dz8 : dz32;     endfunction
   function automatic logic [31:0] g_hi(input int s); return s != 0 ? {24'h0, hi8} : hi32; endfunction
   function automatic logic [31:0] g_lo(input int s); return s != 0 ? {24'h0, lo8} : lo32; endfunction

   task automatic drv(input int s, input logic st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic cn);
      if (s != 0) begin
         st8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; cn8 = cn;
      end else begin
         st32 = st; op32 = op; a32 = a; b32 = b; cn32 = cn;
      end
   endtask

   // Reference: plain integer arithmetic on w-bit two's complement values.
   function automatic void model(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo, inout logic dz);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, m, p;
      m  = (64'd1 << w) - 64'd1;
      ua = 64'(a) & m;
      ub = 64'(b) & m;
      sa = a[w-1] ? $signed(ua) - (64'sd1 <<< w) : $signed(ua);
      sb = b[w-1] ? $signed(ub) - (64'sd1 <<< w) : $signed(ub);
      case (op)
         3'd0, 3'd1: begin
            p  = (op == 3'd0) ? $unsigned(sa * sb) : ua * ub;
            hi = 32'((p >> w) & m);
            lo = 32'(p & m);
         end
         3'd2, 3'd3: begin
            if (ub == 64'd0) begin
               hi = 32'(ua);
               lo = 32'(m);
               dz = 1'b1;
            end else begin
               if (op == 3'd2) begin
                  q = sa / sb;
                  r = sa % sb;
               end else begin
                  q = $signed(ua / ub);
                  r = $signed(ua % ub);
               end
               lo = 32'($unsigned(q) & m);
               hi = 32'($unsigned(r) & m);
               dz = 1'b0;
            end
         end
         3'd4: hi = 32'(ua);
         3'd5: lo = 32'(ua);
         default: ;
      endcase
   endfunction

   // Arithmetic op; cancel_at in 1..w+1 aborts, anything else completes.
   task automatic arith(input int s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cancel_at);
      int          w, first, ndone;
      logic [31:0] xh, xl;
      logic        xd, aborted;
      w  = (s != 0) ? 8 : 32;
      xh = e_hi[s]; xl = e_lo[s]; xd = e_dz[s];
      aborted = (cancel_at >= 1) && (cancel_at <= w + 1);
      if (!aborted) model(w, op, a, b, xh, xl, xd);
      drv(s, 1'b1, op, a, b, 1'b0);
      first = -1;
      ndone = 0;
      for (int n = 1; n <= w + 4; n++) begin
         @(negedge clk);
         if (n == 1) begin
            drv(s, 1'b0, op, a, b, 1'b0);
            chk("busy_cycle1", g_busy(s), 1'b1);
         end
         if (n == 4) drv(s, 1'b1, 3'd4, 32'hDEADBEEF, b, 1'b0);
         if (n == 5) drv(s, 1'b0, op, a, b, 1'b0);
         if (n == cancel_at) drv(s, 1'b0, op, a, b, 1'b1);
         if (n == cancel_at + 1) begin
            drv(s, 1'b0, op, a, b, 1'b0);
            if (aborted) chk("busy_after_cancel", g_busy(s), 1'b0);
         end
         if (!aborted && n == w + 2) chk("busy_in_fin", g_busy(s), 1'b1);
         if (!aborted && n == w + 3) chk("busy_after_fin", g_busy(s), 1'b0);
         if (g_done(s)) begin
            ndone++;
            if (first < 0) begin
               first = n;
               chk("hi_at_done", g_hi(s), xh);
               chk("lo_at_done", g_lo(s), xl);
               chk("div0_at_done", g_dz(s), xd);
            end
         end
      end
      if (aborted) begin
         chk("done_count_aborted", ndone, 0);
      end else begin
         chk("done_latency", first, w + 2);
         chk("done_count", ndone, 1);
      end
      chk("hi_final", g_hi(s), xh);
      chk("lo_final", g_lo(s), xl);
      chk("div0_final", g_dz(s), xd);
      chk("busy_final", g_busy(s), 1'b0);
      e_hi[s] = xh; e_lo[s] = xl; e_dz[s] = xd;
   endtask

   // MTHI/MTLO/no-op codes: single-edge effect, never busy or done.
   task automatic mt(input int s, input logic [2:0] op, input logic [31:0] a, input logic cn);
      int          w;
      logic [31:0] xh, xl;
      logic        xd;
      w  = (s != 0) ? 8 : 32;
      xh = e_hi[s]; xl = e_lo[s]; xd = e_dz[s];
      if (!cn) model(w, op, a, 32'h0, xh, xl, xd);
      drv(s, 1'b1, op, a, 32'h0, cn);
      @(negedge clk);
      drv(s, 1'b0, op, a, 32'h0, 1'b0);
      chk("mt_hi", g_hi(s), xh);
      chk("mt_lo", g_lo(s), xl);
      chk("mt_busy", g_busy(s), 1'b0);
      chk("mt_done", g_done(s), 1'b0);
      @(negedge clk);
      chk("mt_busy_next", g_busy(s), 1'b0);
      e_hi[s] = xh; e_lo[s] = xl; e_dz[s] = xd;
   endtask

   initial begin
      int          s;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      rst_n = 1'b0;
      drv(0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      drv(1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         e_hi[i] = 32'h0; e_lo[i] = 32'h0; e_dz[i] = 1'b0;
      end
      #3;
      for (int i = 0; i < 2; i++) begin
         chk("rst_hi", g_hi(i), 32'h0);
         chk("rst_lo", g_lo(i), 32'h0);
         chk("rst_busy", g_busy(i), 1'b0);
         chk("rst_done", g_done(i), 1'b0);
         chk("rst_div0", g_dz(i), 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      arith(0, MDU_MULT,  32'hFFFFFFFE, 32'h00000003, 0);
      chk("mult_neg2x3_hi", hi32, 32'hFFFFFFFF);
      chk("mult_neg2x3_lo", lo32, 32'hFFFFFFFA);
      arith(0, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      chk("multu_max_hi", hi32, 32'hFFFFFFFE);
      chk("multu_max_lo", lo32, 32'h00000001);
      arith(0, MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 0);
      chk("div_m7_2_lo", lo32, 32'hFFFFFFFD);
      chk("div_m7_2_hi", hi32, 32'hFFFFFFFF);
      arith(0, MDU_DIVU,  32'h7, 32'h0, 0);
      chk("divu_7_0_lo", lo32, 32'hFFFFFFFF);
      chk("divu_7_0_hi", hi32, 32'h7);
      chk("divu_7_0_div0", dz32, 1'b1);
      arith(0, MDU_MULT,  32'h3, 32'h3, 0);
      chk("div0_kept_by_mult", dz32, 1'b1);
      arith(0, MDU_DIVU,  32'h7, 32'h2, 0);
      chk("divu_7_2_lo", lo32, 32'h3);
      chk("divu_7_2_hi", hi32, 32'h1);
      chk("divu_7_2_div0", dz32, 1'b0);
      arith(0, MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 0);
      chk("div_min_m1_lo", lo32, 32'h80000000);
      chk("div_min_m1_hi", hi32, 32'h0);
      arith(0, MDU_DIV,   32'hFFFFFFF9, 32'h0, 0);

      arith(0, MDU_MULT,  32'h5, 32'h5, 10);
      arith(1, MDU_DIVU,  32'hC8, 32'h7, 9);
      arith(0, MDU_DIV,   32'd100, 32'hFFFFFFFD, 34);

      mt(0, MDU_MTHI, 32'h12345678, 1'b0);
      chk("mthi_value", hi32, 32'h12345678);
      mt(0, MDU_MTLO, 32'h0BADF00D, 1'b0);
      mt(0, MDU_MTLO, 32'h0000CAFE, 1'b1);
      mt(1, 3'd6, 32'h55, 1'b0);

      arith(1, MDU_MULT, 32'h80, 32'h80, 0);
      chk("w8_mult_hi", hi8, 8'h40);
      chk("w8_mult_lo", lo8, 8'h00);

      drv(0, 1'b1, MDU_DIV, 32'hFFFF0000, 32'h3, 1'b0);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) drv(0, 1'b0, MDU_DIV, 32'hFFFF0000, 32'h3, 1'b0);
         if (n < 20) chk("pre_reset_no_done", done32, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("midop_rst_hi", g_hi(i), 32'h0);
         chk("midop_rst_lo", g_lo(i), 32'h0);
         chk("midop_rst_busy", g_busy(i), 1'b0);
         chk("midop_rst_done", g_done(i), 1'b0);
         chk("midop_rst_div0", g_dz(i), 1'b0);
         e_hi[i] = 32'h0; e_lo[i] = 32'h0; e_dz[i] = 1'b0;
      end
      @(negedge clk);
      chk("held_rst_done", done32, 1'b0);
      rst_n = 1'b1;
      arith(0, MDU_MULTU, 32'h00010001, 32'h00000101, 0);

      for (int k = 0; k < 60; k++) begin
         s  = k % 2;
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 5) == 0) rb = 32'h0;
         if ($urandom_range(0, 7) == 0) ra = (s != 0) ? 32'h80 : 32'h80000000;
         if (rop < 3'd4) arith(s, rop, ra, rb, 0);
         else            mt(s, rop, ra, 1'(($urandom_range(0, 3) == 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values even, 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request strobe, sampled when not busy.
REQ-005 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others no-op.
REQ-006 SHALL have port in1, in2  input  WIDTH each  rs/rt operands; MTHI/MTLO use in1.
REQ-007 SHALL have port cancel  input  1  pipeline flush; aborts an operation in flight.
REQ-008 SHALL have port busy  output  1  high while an arithmetic op is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse when HI/LO take a new arithmetic result.
REQ-010 SHALL have port div0  output  1  sticky flag: last completed divide had in2==0.
REQ-011 SHALL have port hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, FIN.
REQ-013 In IDLE, start with op MULT/MULTU/DIV/DIVU SHALL latch operands and op, enter CALC, set busy next cycle.
REQ-014 In IDLE, start with MTHI/MTLO SHALL write in1 to hi/lo at that edge; no busy, no done; state stays IDLE.
REQ-015 start SHALL be ignored whenever busy is high.
REQ-016 CALC SHALL last exactly WIDTH cycles, one bit per cycle: radix-2 shift-add multiply, restoring divide, on operand magnitudes.
REQ-017 Signed ops SHALL take magnitudes at latch time; FIX (one cycle) SHALL negate: product if signs differ, quotient if signs differ, remainder if dividend negative.
REQ-018 FIN SHALL load hi/lo and pulse done for that one cycle, then return to IDLE; busy high from the cycle after the start edge through FIN.
REQ-019 done SHALL therefore be high in the cycle WIDTH+2 after the start edge, for all four ops, including divide-by-zero.
REQ-020 Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product.
REQ-021 Divide result: lo = quotient truncated toward zero, hi = remainder with dividend's sign.
REQ-022 Divide by zero: lo = all ones, hi = in1 unchanged, div0 set at FIN; any non-zero divide clears div0 at FIN; multiplies leave div0 unchanged.
REQ-023 Signed DIV of most-negative by -1: lo = most-negative, hi = 0; no trap.
REQ-024 cancel in CALC or FIX SHALL return to IDLE next edge, busy low, no done, hi/lo/div0 unchanged.
REQ-025 cancel in FIN SHALL NOT suppress the write (result already committed); cancel in IDLE SHALL suppress a same-cycle start, including MTHI/MTLO.
REQ-026 hi, lo, busy, done, div0 SHALL be driven directly from registers.

Reset
REQ-027 reset low SHALL immediately force IDLE, hi=0, lo=0, busy=0, done=0, div0=0, counter=0, datapath registers=0.
REQ-028 reset asserted mid-operation SHALL discard the operation with no done pulse; first start is accepted at the first rising edge after release.

Structure
REQ-029 Op encodings (MDU_MULT..MDU_MTLO) and FSM state encodings SHALL live in the shared CPU definitions package, also used by the decoder.
REQ-030 Iteration counter SHALL be $clog2(WIDTH+1) bits.
REQ-031 One sub-module is natural: mdu_divstep (combinational restoring-divide step: partial remainder, divisor -> next remainder, quotient bit); the multiply step stays inline.

Verification
REQ-032 WIDTH=32, MULT in1=0xFFFFFFFE (-2), in2=0x00000003 -> done at cycle 34 after start, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 MULTU in1=in2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV in1=0xFFFFFFF9 (-7), in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, div0=1; following DIVU 7/2 -> lo=3, hi=1, div0=0.
REQ-035 MULT 5x5 started, cancel asserted at cycle 10 -> busy low at cycle 11, no done, hi/lo keep prior values; start re-issued while busy ignored.
REQ-036 MTHI in1=0x12345678 -> hi=0x12345678 next edge, busy and done stay low; reset pulsed during DIV at cycle 20 -> all outputs 0 immediately, no done.
REQ-037 WIDTH=8 instance: MULT 0x80 x 0x80 -> hi=0x40, lo=0x00, done at cycle 10.
